// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store controller for a 64-word memory without byte enables (SB/SH use read-modify-write)
module load_store_unit #(
  parameter int ADDR_W     = 8,
  parameter int WORD_IDX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wbuf_q, wbuf_d, rdata_q, rdata_d;
  logic              load_q, load_d, err_q, err_d;
  logic              ld_ok, st_ok, illegal, misal;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ld_val, mask, ins;
  always_comb begin
    ld_ok   = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok   = req_funct3 inside {3'b000, 3'b001, 3'b010};
    illegal = (req_is_load == req_is_store) || (req_is_load && !ld_ok) || (req_is_store && !st_ok);
    misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    lane_b  = 8'(mem_read_data >> {addr_q[1:0], 3'b000});
    lane_h  = 16'(mem_read_data >> {addr_q[1], 4'b0000});
    ld_val  = f3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
              f3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
              f3_q == 3'b100 ? {24'b0, lane_b} :
              f3_q == 3'b101 ? {16'b0, lane_h} : mem_read_data;
    // wbuf still holds the store data while in RMW_RD; replicate it so the mask picks the right lane
    mask    = f3_q[0] ? 32'h0000_ffff << {addr_q[1], 4'b0000} : 32'h0000_00ff << {addr_q[1:0], 3'b000};
    ins     = f3_q[0] ? {2{wbuf_q[15:0]}} : {4{wbuf_q[7:0]}};
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    load_d  = load_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        f3_d    = req_funct3;
        wbuf_d  = req_wdata;
        rdata_d = '0;
        load_d  = req_is_load;
        err_d   = illegal || misal;
        state_d = (illegal || misal) ? RESP : req_is_load ? RD : req_funct3[1] ? WR : RMW_RD;
      end
      RD: begin
        rdata_d = ld_val;
        state_d = RESP;
      end
      RMW_RD: begin
        wbuf_d  = (mem_read_data & ~mask) | (ins & mask);
        state_d = WR;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end
  assign req_ready      = state_q == IDLE;
  assign mem_read       = state_q == RD || state_q == RMW_RD;
  assign mem_write      = state_q == WR;
  assign mem_addr       = (mem_read || mem_write) ? ADDR_W'(addr_q[WORD_IDX_W+1:2]) : '0;
  assign mem_write_data = mem_write ? wbuf_q : '0;
  assign resp_valid     = state_q == RESP;
  assign resp_err       = resp_valid && err_q;
  assign resp_rdata     = (resp_valid && load_q && !err_q) ? rdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + random checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_is_load = 1'b0, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [7:0]  req_addr = '0, mem_addr;
  logic [31:0] req_wdata = '0, resp_rdata, mem_write_data, mem_read_data;
  logic        resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  int          errors = 0, checks = 0;
  logic [31:0] g;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic ld, input logic st, input logic [2:0] f3, input logic [7:0] a,
                    input logic [31:0] wd, input string tag, output logic [31:0] got);
    int sz, idx, off, lat, n;
    bit legal, err, saw_rd, saw_wr, both;
    longint v;
    logic [31:0] nw, exp_rd;
    sz     = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : f3[1:0] == 2'd2 ? 4 : 0;
    legal  = (ld != st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2}));
    err    = !legal;
    if (legal && (int'(a) % sz) != 0) err = 1;
    idx    = int'(a) / 4;
    off    = int'(a) % 4;
    nw     = ref_mem[idx];
    exp_rd = '0;
    if (!err && ld) begin
      v = (longint'(ref_mem[idx]) >> (8 * off)) % (longint'(1) << (8 * sz));
      if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
      exp_rd = v[31:0];
    end
    if (!err && st) for (int k = 0; k < sz; k++) nw[8*(off+k) +: 8] = wd[8*k +: 8];
    lat = err ? 1 : (st && sz < 4) ? 3 : 2;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_is_load = ld; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    n = 1; saw_rd = 0; saw_wr = 0; both = 0;
    while (!resp_valid && n < 8) begin
      if (mem_read && mem_write) both = 1;
      if (mem_read) saw_rd = 1;
      if (mem_write) begin
        saw_wr = 1;
        check({tag, "_waddr"}, {24'b0, mem_addr}, 32'(idx));
        check({tag, "_wdata"}, mem_write_data, nw);
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_err"}, {31'b0, resp_err}, {31'b0, err});
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_rd_seen"}, {31'b0, saw_rd}, {31'b0, !err && (ld || sz < 4)});
    check({tag, "_wr_seen"}, {31'b0, saw_wr}, {31'b0, !err && st});
    check({tag, "_overlap"}, {31'b0, both}, 32'd0);
    got = resp_rdata;
    if (!err && st) ref_mem[idx] = nw;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int n;
    logic [31:0] wd;
    logic ld, st;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {27'b0, resp_valid, resp_err, mem_read, mem_write, req_ready}, 32'd1);
    check("rst_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    reset = 0;
    @(posedge clk); #1;
    op(0, 1, 3'b010, 8'h10, 32'hDEADBEEF, "sw", g);
    op(1, 0, 3'b000, 8'h13, 32'h0, "lb", g);  check("lb_val", g, 32'hFFFFFFDE);
    op(1, 0, 3'b100, 8'h13, 32'h0, "lbu", g); check("lbu_val", g, 32'h000000DE);
    op(1, 0, 3'b001, 8'h10, 32'h0, "lh", g);  check("lh_val", g, 32'hFFFFBEEF);
    op(1, 0, 3'b101, 8'h12, 32'h0, "lhu", g); check("lhu_val", g, 32'h0000DEAD);
    op(1, 0, 3'b010, 8'h10, 32'h0, "lw", g);  check("lw_val", g, 32'hDEADBEEF);
    op(0, 1, 3'b000, 8'h11, 32'h12345677, "sb", g); check("sb_word", mem[4], 32'hDEAD77EF);
    op(0, 1, 3'b001, 8'h12, 32'h0000CAFE, "sh", g); check("sh_word", mem[4], 32'hCAFE77EF);
    op(1, 0, 3'b010, 8'h11, 32'h0, "mis_lw", g);
    op(1, 0, 3'b001, 8'h13, 32'h0, "mis_lh", g);
    op(0, 1, 3'b010, 8'h02, 32'h55, "mis_sw", g);
    op(1, 1, 3'b010, 8'h10, 32'h0, "ill_both", g);
    op(1, 0, 3'b011, 8'h10, 32'h0, "ill_f3", g);
    op(0, 0, 3'b010, 8'h10, 32'h0, "ill_none", g);
    op(0, 1, 3'b100, 8'h10, 32'h0, "ill_sf3", g);
    // reset during the read half of a byte store
    req_valid = 1; req_is_load = 0; req_is_store = 1; req_funct3 = 3'b000; req_addr = 8'h21; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 0;
    check("abort_rmw_rd", {31'b0, mem_read}, 32'd1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("abort_quiet", {30'b0, mem_write, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check("abort_mem", mem[8], ref_mem[8]);
    // back-to-back: SW then LW with req_valid held high
    wd = $urandom;
    req_valid = 1; req_is_load = 0; req_is_store = 1; req_funct3 = 3'b010; req_addr = 8'h30; req_wdata = wd;
    @(posedge clk); #1;
    req_is_load = 1; req_is_store = 0;
    n = 1;
    while (!req_ready && n < 8) begin
      check("b2b_overlap", {31'b0, mem_read && mem_write}, 32'd0);
      if (n == 2) check("b2b_resp1", {30'b0, resp_valid, resp_err}, 32'd2);
      @(posedge clk); #1;
      n++;
    end
    check("b2b_accept", 32'(n), 32'd3);
    ref_mem[12] = wd;
    @(posedge clk); #1;
    req_valid = 0;
    check("b2b_rd", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1;
    check("b2b_resp2", {30'b0, resp_valid, resp_err}, 32'd2);
    check("b2b_rdata", resp_rdata, wd);
    @(posedge clk); #1;
    for (int i = 0; i < 150; i++) begin
      ld = 1'($urandom % 2);
      st = ($urandom % 10 == 0) ? ld : !ld;
      op(ld, st, 3'($urandom % 8), 8'h40 + 8'($urandom % 32), $urandom, "rnd", g);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
